// File: rtl/div_unit_if.sv
// Request/response bundle between the execute-stage control and the iterative divider.
interface div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, op, a, b, input busy, done, result);
  modport slave  (input start, op, a, b, output busy, done, result);
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU; one quotient bit per cycle.
// state  | meaning
// S_IDLE | waiting for start
// S_CALC | shift-subtract iterations, counter runs WIDTH-1 down to 0
// S_FIX  | sign correction (or special-case select), writes result
// S_DONE | one-cycle completion pulse; start here chains the next op
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
  state_t state_q, state_d;

  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] div_q;
  logic [CW-1:0]    cnt_q;
  logic             spec_q, bz_q, neg_q, sa_q;
  logic [WIDTH-1:0] result_q;

  logic             accept, is_signed, b_zero, ovf, special;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH+1:0] sh, trial;
  logic [WIDTH-1:0] q_fix, r_fix, fix_res;

  assign accept    = bus.start && (state_q == S_IDLE || state_q == S_DONE);
  assign is_signed = ~bus.op[0];
  assign b_zero    = (bus.b == '0);
  assign ovf       = is_signed && (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);
  assign special   = b_zero || ovf;
  assign mag_a     = (is_signed && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
  assign mag_b     = (is_signed && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;

  // Extra top bit keeps the trial sign unambiguous while the shifted remainder spans WIDTH+1 bits.
  assign sh    = {rem_q, quo_q[WIDTH-1]};
  assign trial = sh - {2'b00, div_q};

  assign q_fix = neg_q ? (~quo_q + 1'b1) : quo_q;
  assign r_fix = sa_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];

  always_comb begin
    fix_res = op_q[1] ? r_fix : q_fix;
    if (spec_q) begin
      if (bz_q) fix_res = op_q[1] ? a_q : '1;
      else      fix_res = op_q[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) state_d = special ? S_FIX : S_CALC;
        else        state_d = S_IDLE;
      end
      S_CALC:  if (cnt_q == '0) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      a_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      spec_q   <= 1'b0;
      bz_q     <= 1'b0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      op_q   <= bus.op;
      a_q    <= bus.a;
      rem_q  <= '0;
      quo_q  <= mag_a;
      div_q  <= mag_b;
      cnt_q  <= CW'(WIDTH - 1);
      spec_q <= special;
      bz_q   <= b_zero;
      neg_q  <= is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      sa_q   <= is_signed && bus.a[WIDTH-1];
    end else if (state_q == S_CALC) begin
      rem_q <= trial[WIDTH+1] ? sh[WIDTH:0] : trial[WIDTH:0];
      quo_q <= {quo_q[WIDTH-2:0], ~trial[WIDTH+1]};
      cnt_q <= cnt_q - 1'b1;
    end else if (state_q == S_FIX) begin
      result_q <= fix_res;
    end
  end

  assign bus.busy   = (state_q == S_CALC) || (state_q == S_FIX);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: arithmetic, special cases, handshake and reset abort.
module tb_div_unit;
  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errors  = 0;

  div_unit_if #(.WIDTH(32)) bus();
  div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Counts edges after the current point until done is seen (bounded).
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        output logic [31:0] res, output int lat, output int busy_cnt);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a = av; bus.b = bv;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat, busy_cnt);
    res = bus.result;
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    vectors++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", bus.result); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned;
    logic [31:0] r; int l, bc;
    run_op(DIVU, 32'd100, 32'd7, r, l, bc);
    vectors++; if (r !== 32'd14) begin errors++; $display("FAIL divu_100_7: got %h expected %h", r, 32'd14); end
    vectors++; if (l != 33) begin errors++; $display("FAIL divu_latency: got %0d expected 33", l); end
    vectors++; if (bc != 33) begin errors++; $display("FAIL divu_busy_cycles: got %0d expected 33", bc); end
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL divu_busy_at_done: got %b expected 0", bus.busy); end
    @(posedge clk); #1;
    vectors++; if (bus.done !== 1'b0) begin errors++; $display("FAIL divu_done_width: got %b expected 0", bus.done); end
    vectors++; if (bus.result !== 32'd14) begin errors++; $display("FAIL divu_result_hold: got %h expected %h", bus.result, 32'd14); end
    run_op(REMU, 32'd100, 32'd7, r, l, bc);
    vectors++; if (r !== 32'd2) begin errors++; $display("FAIL remu_100_7: got %h expected 2", r); end
    vectors++; if (l != 33) begin errors++; $display("FAIL remu_latency: got %0d expected 33", l); end
    run_op(DIVU, 32'hFFFFFFFF, 32'd1, r, l, bc);
    vectors++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu_max_1: got %h expected ffffffff", r); end
  endtask

  task automatic test_signed;
    logic [31:0] r; int l, bc;
    run_op(DIV, 32'hFFFFFFEC, 32'd3, r, l, bc);
    vectors++; if (r !== 32'hFFFFFFFA) begin errors++; $display("FAIL div_m20_3: got %h expected fffffffa", r); end
    vectors++; if (l != 33) begin errors++; $display("FAIL div_latency: got %0d expected 33", l); end
    run_op(REM, 32'hFFFFFFEC, 32'd3, r, l, bc);
    vectors++; if (r !== 32'hFFFFFFFE) begin errors++; $display("FAIL rem_m20_3: got %h expected fffffffe", r); end
    run_op(REM, 32'd20, 32'hFFFFFFFD, r, l, bc);
    vectors++; if (r !== 32'd2) begin errors++; $display("FAIL rem_20_m3: got %h expected 2", r); end
    run_op(DIV, 32'd20, 32'hFFFFFFFD, r, l, bc);
    vectors++; if (r !== 32'hFFFFFFFA) begin errors++; $display("FAIL div_20_m3: got %h expected fffffffa", r); end
  endtask

  task automatic test_div_zero;
    logic [31:0] r; int l, bc;
    logic [1:0]  ops [4] = '{DIVU, DIV, REMU, REM};
    logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd5};
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], 32'd5, 32'd0, r, l, bc);
      vectors++; if (r !== exp[i]) begin errors++; $display("FAIL divzero_op%0d: got %h expected %h", ops[i], r, exp[i]); end
      vectors++; if (l != 1) begin errors++; $display("FAIL divzero_latency_op%0d: got %0d expected 1", ops[i], l); end
      vectors++; if (bc != 1) begin errors++; $display("FAIL divzero_busy_op%0d: got %0d expected 1", ops[i], bc); end
    end
  endtask

  task automatic test_overflow;
    logic [31:0] r; int l, bc;
    run_op(DIV, 32'h80000000, 32'hFFFFFFFF, r, l, bc);
    vectors++; if (r !== 32'h80000000) begin errors++; $display("FAIL ovf_div: got %h expected 80000000", r); end
    vectors++; if (l != 1) begin errors++; $display("FAIL ovf_div_latency: got %0d expected 1", l); end
    run_op(REM, 32'h80000000, 32'hFFFFFFFF, r, l, bc);
    vectors++; if (r !== 32'h0) begin errors++; $display("FAIL ovf_rem: got %h expected 0", r); end
    vectors++; if (l != 1) begin errors++; $display("FAIL ovf_rem_latency: got %0d expected 1", l); end
    run_op(DIVU, 32'h80000000, 32'hFFFFFFFF, r, l, bc);
    vectors++; if (r !== 32'h0 || l != 33) begin errors++; $display("FAIL ovf_divu_normal: got %h/%0d expected 0/33", r, l); end
  endtask

  task automatic test_ignore_start;
    int l, bc, extra;
    @(negedge clk);
    bus.start = 1'b1; bus.op = DIVU; bus.a = 32'd200; bus.b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = REMU; bus.a = 32'd1; bus.b = 32'd1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.op = DIVU; bus.a = 32'd50; bus.b = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(l, bc);
    vectors++; if (bus.result !== 32'd28) begin errors++; $display("FAIL ignore_result: got %h expected %h", bus.result, 32'd28); end
    vectors++; if (l + 5 != 33) begin errors++; $display("FAIL ignore_latency: got %0d expected 33", l + 5); end
    extra = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.done || bus.busy) extra++; end
    vectors++; if (extra != 0) begin errors++; $display("FAIL ignore_no_queue: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r; int l, bc;
    run_op(DIVU, 32'd100, 32'd7, r, l, bc);
    vectors++; if (r !== 32'd14) begin errors++; $display("FAIL b2b_first: got %h expected %h", r, 32'd14); end
    bus.start = 1'b1; bus.op = REMU; bus.a = 32'd100; bus.b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    vectors++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL b2b_accept: got busy=%b done=%b expected busy=1 done=0", bus.busy, bus.done); end
    wait_done(l, bc);
    vectors++; if (l != 33) begin errors++; $display("FAIL b2b_latency: got %0d expected 33", l); end
    vectors++; if (bus.result !== 32'd2) begin errors++; $display("FAIL b2b_second: got %h expected 2", bus.result); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r; int l, bc, seen;
    @(negedge clk);
    bus.start = 1'b1; bus.op = DIVU; bus.a = 32'd100; bus.b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", bus.done); end
    vectors++; if (bus.result !== 32'h0) begin errors++; $display("FAIL rstmid_result: got %h expected 0", bus.result); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.done) seen++; end
    vectors++; if (seen != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", seen); end
    run_op(DIVU, 32'd9, 32'd3, r, l, bc);
    vectors++; if (r !== 32'd3 || l != 33) begin errors++; $display("FAIL rstmid_after: got %h/%0d expected 3/33", r, l); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
